// File: rtl/spi_word_bridge.sv
// SPI mode-0 slave moving 16-bit words between an SPI host and a word bus.
// Optional SPI_TX_MARKER_EN: frames with no pending tx word shift out 16'hFFFF.
module spi_word_bridge #(
   parameter int WORD_SIZE   = 16,
   parameter int VALID_HOLD  = 4,
   parameter int READY_HOLD  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 spi_sck,
   input  logic                 spi_cs_n,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 spi_2_bus_valid,
   output logic [WORD_SIZE-1:0] spi_2_bus_data,
   input  logic                 bus_2_spi_valid,
   input  logic [WORD_SIZE-1:0] bus_2_spi_data,
   output logic                 bus_2_spi_ready,
   output logic                 rx_overrun,
   output logic                 tx_underrun
);

`ifdef SPI_TX_MARKER_EN
   localparam logic [WORD_SIZE-1:0] UNDERRUN_WORD = '1;
`else
   localparam logic [WORD_SIZE-1:0] UNDERRUN_WORD = '0;
`endif

   localparam int CW  = $clog2(WORD_SIZE);
   localparam int VCW = $clog2(VALID_HOLD + 3);
   localparam int RCW = $clog2(READY_HOLD + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] sck_sy, cs_sy, mosi_sy;
   logic                   sck_d, cs_d;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise, sck_fall, cs_fall;

   logic [CW-1:0]          bit_cnt;
   logic [WORD_SIZE-2:0]   rx_shift;
   logic [WORD_SIZE-1:0]   word;
   logic                   end_pend;
   logic [VCW-1:0]         vcnt;

   logic [WORD_SIZE-1:0]   tx_shift, tx_buf;
   logic                   tx_pending, pend_after;
   logic [RCW-1:0]         rcnt;

   logic start, stop, rise, fall;
   logic word_done, load, shift;

   assign sck_s    = sck_sy[SYNC_STAGES-1];
   assign cs_s     = cs_sy[SYNC_STAGES-1];
   assign mosi_s   = mosi_sy[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign cs_fall  = ~cs_s & cs_d;
   assign word     = {rx_shift, mosi_s};
   assign spi_miso = (state == SHIFT) & tx_shift[WORD_SIZE-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sck_sy  <= '0;
         cs_sy   <= '1;
         mosi_sy <= '0;
         sck_d   <= 1'b0;
         cs_d    <= 1'b1;
      end else begin
         sck_sy  <= {sck_sy[SYNC_STAGES-2:0], spi_sck};
         cs_sy   <= {cs_sy[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], spi_mosi};
         sck_d   <= sck_s;
         cs_d    <= cs_s;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      start   = 1'b0;
      stop    = 1'b0;
      rise    = 1'b0;
      fall    = 1'b0;
      unique case (state)
         IDLE: begin
            if (cs_fall) begin
               state_n = SHIFT;
               start   = 1'b1;
            end
         end
         SHIFT: begin
            if (cs_s) begin
               state_n = IDLE;
               stop    = 1'b1;
            end else begin
               rise = sck_rise;
               fall = sck_fall;
            end
         end
         default: state_n = IDLE;
      endcase
      word_done  = rise && (bit_cnt == CW'(WORD_SIZE - 1));
      load       = start || (fall && end_pend);
      shift      = fall && !end_pend;
      pend_after = load ? 1'b0 : tx_pending;
   end

   // Receive side; the hold counter also covers a 2-cycle gap after valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt         <= '0;
         rx_shift        <= '0;
         end_pend        <= 1'b0;
         vcnt            <= '0;
         spi_2_bus_valid <= 1'b0;
         spi_2_bus_data  <= '0;
         rx_overrun      <= 1'b0;
      end else begin
         if (start || stop) begin
            bit_cnt  <= '0;
            end_pend <= 1'b0;
         end else begin
            if (rise) begin
               rx_shift <= word[WORD_SIZE-2:0];
               bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
            end
            if (word_done)             end_pend <= 1'b1;
            else if (fall && end_pend) end_pend <= 1'b0;
         end
         if (word_done && vcnt == '0) begin
            spi_2_bus_data <= word;
            vcnt           <= VCW'(VALID_HOLD + 2);
         end else begin
            if (word_done) rx_overrun <= 1'b1;
            if (vcnt != '0) vcnt <= vcnt - 1'b1;
         end
         spi_2_bus_valid <= vcnt > VCW'(2);
      end
   end

   // Transmit side; a load and a capture may coincide
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_shift        <= '0;
         tx_buf          <= '0;
         tx_pending      <= 1'b0;
         rcnt            <= '0;
         bus_2_spi_ready <= 1'b0;
         tx_underrun     <= 1'b0;
      end else begin
         if (load) begin
            if (tx_pending) begin
               tx_shift <= tx_buf;
            end else begin
               tx_shift    <= UNDERRUN_WORD;
               tx_underrun <= 1'b1;
            end
         end else if (shift) begin
            tx_shift <= {tx_shift[WORD_SIZE-2:0], 1'b0};
         end
         if (bus_2_spi_valid && !pend_after) begin
            tx_buf     <= bus_2_spi_data;
            tx_pending <= 1'b1;
         end else begin
            tx_pending <= pend_after;
         end
         if (load && tx_pending) rcnt <= RCW'(READY_HOLD);
         else if (rcnt != '0)    rcnt <= rcnt - 1'b1;
         bus_2_spi_ready <= rcnt != '0;
      end
   end

endmodule
